perceptron_trainer: RTL and testbench
=====================================

PERCEPTRON_TRAINER -- requirements
Module: perceptron_trainer

Interface
REQ-001 SHALL have parameter DIM, default 2, meaning features per sample (1..8).
REQ-002 SHALL have parameter SAMPLES, default 4, meaning sample-store depth (1..16).
REQ-003 SHALL have parameter XW, default 4, meaning signed feature width.
REQ-004 SHALL have parameter WW, default 8, meaning signed weight/bias width.
REQ-005 SHALL have parameter MAX_EPOCHS, default 15, meaning epoch limit (1..255).
REQ-006 SHALL have port clk  input  1  single clock, rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port clear  input  1  synchronous clear of samples and weights, honoured in IDLE only.
REQ-009 SHALL have port load_valid  input  1  feature beat valid.
REQ-010 SHALL have port load_ready  output  1  feature beat can be accepted.
REQ-011 SHALL have port load_x  input  XW  signed feature value.
REQ-012 SHALL have port load_label  input  1  class label, sampled on the last beat of a sample.
REQ-013 SHALL have port start  input  1  training request.
REQ-014 SHALL have port busy  output  1  training in progress.
REQ-015 SHALL have port done  output  1  one-cycle pulse at training end.
REQ-016 SHALL have port converged  output  1  last run ended with a zero-error epoch.
REQ-017 SHALL have port epochs  output  8  epochs completed in last/current run.
REQ-018 SHALL have port n_loaded  output  clog2(SAMPLES+1)  complete samples stored.
REQ-019 SHALL have port w_idx  input  clog2(DIM+1)  weight select; DIM selects bias.
REQ-020 SHALL have port w_rd  output  WW  combinational weight/bias readout; 0 when w_idx > DIM.

Function
REQ-021 FSM states: IDLE, MAC, UPDATE, EPOCH_END, DONE.
REQ-022 load_ready = (state==IDLE) && (n_loaded<SAMPLES); beat accepted on load_valid && load_ready.
REQ-023 DIM beats form one sample, in feature order 0..DIM-1; n_loaded increments on the DIM-th beat.
REQ-024 start accepted only in IDLE, n_loaded>0, no partial sample pending, and no beat accepted in that cycle; otherwise ignored.
REQ-025 Start acceptance: epochs:=0, converged:=0, error count:=0, sample index:=0, state:=MAC.
REQ-026 MAC: accumulator loaded with bias on entry, adds w[d]*x[d] for one feature per cycle; DIM cycles.
REQ-027 Accumulator SHALL be signed, WW+XW+clog2(DIM+1) bits, no overflow.
REQ-028 UPDATE (1 cycle): act = (acc > 0); delta = label - act in {-1,0,+1}.
REQ-029 delta != 0: w[d] += delta*x[d] for all d, bias += delta, error count increments.
REQ-030 Each sample takes DIM+1 cycles; each epoch takes n_loaded*(DIM+1)+1 cycles.
REQ-031 EPOCH_END: epochs increments; zero errors -> converged:=1, DONE; epochs==MAX_EPOCHS -> DONE; otherwise clear error count and re-enter MAC at sample 0.
REQ-032 DONE lasts one cycle with done=1, then IDLE; converged and epochs hold until the next accepted start or clear.
REQ-033 busy = 1 in MAC, UPDATE and EPOCH_END.
REQ-034 clear in IDLE: n_loaded, partial-beat count, weights, bias, epochs and converged := 0; a load beat in the same cycle is dropped.

Reset
REQ-035 rst_n low at any time, including mid-training, forces state IDLE, all weights/bias/counters/epochs := 0, busy=done=converged=0.
REQ-036 During reset and after it, load_ready=1 (empty store); sample contents need not reset.

Configuration
REQ-037 Macro PERCEPTRON_SAT_EN defined: weight and bias updates saturate to [-2^(WW-1), 2^(WW-1)-1].
REQ-038 Macro PERCEPTRON_SAT_EN undefined: updates wrap modulo 2^WW.

Verification
REQ-039 AND set, DIM=2, SAMPLES=4, samples (0,0,0),(0,1,0),(1,0,0),(1,1,1) -> done 78 cycles after start edge, converged=1, epochs=6, w0=2, w1=1, bias=-2.
REQ-040 XOR labels 0,1,1,0, same order -> done with converged=0, epochs=15.
REQ-041 WW=4, XW=4, DIM=1, SAMPLES=2, samples (x=0,L=1),(x=-8,L=0): with PERCEPTRON_SAT_EN -> converged=1, epochs=3, w0=7, bias=1; without -> converged=0, epochs=15, w0=-8, bias=0.
REQ-042 Load SAMPLES samples, then hold load_valid -> load_ready=0, n_loaded stays SAMPLES; start with n_loaded=0 or one beat into a sample -> ignored, busy stays 0.
REQ-043 rst_n low for 1 cycle mid-epoch of the AND run -> busy=0, n_loaded=0, w_rd=0 for all w_idx, no done pulse.
REQ-044 start and load beat in the same IDLE cycle -> beat accepted, start ignored.

Source files
------------

// File: rtl/perceptron_trainer.sv
// Perceptron trainer: stores DIM-feature labelled samples, then applies the perceptron rule
// epoch by epoch until an error-free epoch or MAX_EPOCHS. Define PERCEPTRON_SAT_EN for saturating updates.
module perceptron_trainer #(
    parameter int DIM        = 2,
    parameter int SAMPLES    = 4,
    parameter int XW         = 4,
    parameter int WW         = 8,
    parameter int MAX_EPOCHS = 15
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic signed [XW-1:0]         load_x,
    input  logic                         load_label,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         converged,
    output logic [7:0]                   epochs,
    output logic [$clog2(SAMPLES+1)-1:0] n_loaded,
    input  logic [$clog2(DIM+1)-1:0]     w_idx,
    output logic signed [WW-1:0]         w_rd
);

    localparam int NW = $clog2(SAMPLES + 1);
    localparam int IW = $clog2(DIM + 1);
    localparam int FW = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int SW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
    localparam int AW = WW + XW + IW;
    localparam int UW = ((WW > XW) ? WW : XW) + 2;

    localparam logic signed [UW-1:0] S_MAX    = UW'((2 ** (WW - 1)) - 1);
    localparam logic signed [UW-1:0] S_MIN    = -UW'(2 ** (WW - 1));
    localparam logic signed [UW-1:0] ONE      = UW'(1);
    localparam logic signed [AW-1:0] ACC_ZERO = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_UPDATE,
        S_EPOCH_END,
        S_DONE
    } state_t;

    state_t                state_q;
    logic signed [XW-1:0]  x_mem   [SAMPLES][DIM];
    logic                  lbl_mem [SAMPLES];
    logic signed [WW-1:0]  w_q     [DIM];
    logic signed [WW-1:0]  w_upd   [DIM];
    logic signed [WW-1:0]  bias_q;
    logic signed [WW-1:0]  bias_upd;
    logic signed [AW-1:0]  acc_q;
    logic signed [AW-1:0]  prod;
    logic [NW-1:0]         n_loaded_q;
    logic [NW-1:0]         err_q;
    logic [FW-1:0]         beat_q;
    logic [FW-1:0]         feat_q;
    logic [SW-1:0]         smp_q;
    logic [7:0]            epochs_q;
    logic                  converged_q;
    logic                  done_q;
    logic                  busy_q;

    logic beat_acc;
    logic last_beat;
    logic start_ok;
    logic neg;
    logic mistake;

    // Adds step to a weight; the sum is formed wide enough that the clamp/wrap choice is exact.
    function automatic logic signed [WW-1:0] upd(input logic signed [WW-1:0] w,
                                                 input logic signed [UW-1:0] step);
        logic signed [UW-1:0] s;
        s = UW'(w) + step;
`ifdef PERCEPTRON_SAT_EN
        if (s > S_MAX)      return WW'(S_MAX);
        else if (s < S_MIN) return WW'(S_MIN);
        else                return WW'(s);
`else
        return WW'(s);
`endif
    endfunction

    assign load_ready = (state_q == S_IDLE) && (n_loaded_q < NW'(SAMPLES));
    assign beat_acc   = load_valid && load_ready && !clear;
    assign last_beat  = (beat_q == FW'(DIM - 1));
    assign start_ok   = (state_q == S_IDLE) && start && !clear && (n_loaded_q != '0)
                        && (beat_q == '0) && !(load_valid && load_ready);

    assign prod    = AW'(w_q[feat_q]) * AW'(x_mem[smp_q][feat_q]);
    assign neg     = ~lbl_mem[smp_q];
    assign mistake = lbl_mem[smp_q] != (acc_q > ACC_ZERO);

    always_comb begin
        for (int d = 0; d < DIM; d++) begin
            w_upd[d] = upd(w_q[d], neg ? -UW'(x_mem[smp_q][d]) : UW'(x_mem[smp_q][d]));
        end
        bias_upd = upd(bias_q, neg ? -ONE : ONE);
    end

    // NOTE: the sample store has no reset; its contents are only read below n_loaded, which does reset.
    always_ff @(posedge clk) begin
        if (beat_acc) begin
            x_mem[SW'(n_loaded_q)][beat_q] <= load_x;
            if (last_beat) lbl_mem[SW'(n_loaded_q)] <= load_label;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            for (int d = 0; d < DIM; d++) w_q[d] <= '0;
            bias_q      <= '0;
            acc_q       <= '0;
            n_loaded_q  <= '0;
            err_q       <= '0;
            beat_q      <= '0;
            feat_q      <= '0;
            smp_q       <= '0;
            epochs_q    <= '0;
            converged_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (clear) begin
                        for (int d = 0; d < DIM; d++) w_q[d] <= '0;
                        bias_q      <= '0;
                        n_loaded_q  <= '0;
                        beat_q      <= '0;
                        epochs_q    <= '0;
                        converged_q <= 1'b0;
                    end else begin
                        if (beat_acc) begin
                            if (last_beat) begin
                                beat_q     <= '0;
                                n_loaded_q <= n_loaded_q + 1'b1;
                            end else begin
                                beat_q <= beat_q + 1'b1;
                            end
                        end
                        if (start_ok) begin
                            epochs_q    <= '0;
                            converged_q <= 1'b0;
                            err_q       <= '0;
                            smp_q       <= '0;
                            feat_q      <= '0;
                            busy_q      <= 1'b1;
                            state_q     <= S_MAC;
                        end
                    end
                end
                S_MAC: begin
                    // The first feature of each sample restarts the sum from the current bias.
                    acc_q <= ((feat_q == '0) ? AW'(bias_q) : acc_q) + prod;
                    if (feat_q == FW'(DIM - 1)) begin
                        feat_q  <= '0;
                        state_q <= S_UPDATE;
                    end else begin
                        feat_q <= feat_q + 1'b1;
                    end
                end
                S_UPDATE: begin
                    if (mistake) begin
                        w_q    <= w_upd;
                        bias_q <= bias_upd;
                        err_q  <= err_q + 1'b1;
                    end
                    if (smp_q == SW'(n_loaded_q - 1'b1)) begin
                        state_q <= S_EPOCH_END;
                    end else begin
                        smp_q   <= smp_q + 1'b1;
                        state_q <= S_MAC;
                    end
                end
                S_EPOCH_END: begin
                    epochs_q <= epochs_q + 8'd1;
                    if (err_q == '0) begin
                        converged_q <= 1'b1;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_DONE;
                    end else if (epochs_q == 8'(MAX_EPOCHS - 1)) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        err_q   <= '0;
                        smp_q   <= '0;
                        state_q <= S_MAC;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // NOTE: w_rd gets a default first so no index pattern can leave it unassigned (no latch).
    always_comb begin
        w_rd = '0;
        if (w_idx == IW'(DIM))     w_rd = bias_q;
        else if (w_idx < IW'(DIM)) w_rd = w_q[FW'(w_idx)];
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign converged = converged_q;
    assign epochs    = epochs_q;
    assign n_loaded  = n_loaded_q;

endmodule

// File: tb/tb_perceptron_trainer.sv
// Directed bench for perceptron_trainer: default instance (DIM=2) plus a narrow DIM=1, WW=4 instance.
module tb_perceptron_trainer;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic              clear, load_valid, load_label, start;
    logic signed [3:0] load_x;
    logic [1:0]        w_idx;
    logic              load_ready, busy, done, converged;
    logic [7:0]        epochs;
    logic [2:0]        n_loaded;
    logic signed [7:0] w_rd;

    logic              b_clear, b_load_valid, b_load_label, b_start;
    logic signed [3:0] b_load_x;
    logic              b_w_idx;
    logic              b_load_ready, b_busy, b_done, b_converged;
    logic [7:0]        b_epochs;
    logic [1:0]        b_n_loaded;
    logic signed [3:0] b_w_rd;

    int total = 0;
    int bad   = 0;

`ifdef PERCEPTRON_SAT_EN
    localparam int B_CONV = 1, B_EPOCHS = 3, B_CYCLES = 15, B_W0 = 7, B_BIAS = 1;
`else
    localparam int B_CONV = 0, B_EPOCHS = 15, B_CYCLES = 75, B_W0 = -8, B_BIAS = 0;
`endif

    perceptron_trainer u_dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .load_valid(load_valid),
        .load_ready(load_ready), .load_x(load_x), .load_label(load_label), .start(start),
        .busy(busy), .done(done), .converged(converged), .epochs(epochs),
        .n_loaded(n_loaded), .w_idx(w_idx), .w_rd(w_rd)
    );

    perceptron_trainer #(.DIM(1), .SAMPLES(2), .XW(4), .WW(4), .MAX_EPOCHS(15)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .clear(b_clear), .load_valid(b_load_valid),
        .load_ready(b_load_ready), .load_x(b_load_x), .load_label(b_load_label), .start(b_start),
        .busy(b_busy), .done(b_done), .converged(b_converged), .epochs(b_epochs),
        .n_loaded(b_n_loaded), .w_idx(b_w_idx), .w_rd(b_w_rd)
    );

    // Stimulus helpers: all called at a falling edge and return at a falling edge.
    task automatic beat_a(input logic signed [3:0] x, input logic lbl);
        load_valid = 1'b1; load_x = x; load_label = lbl;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic sample_a(input logic signed [3:0] x0, input logic signed [3:0] x1, input logic lbl);
        beat_a(x0, 1'b0);
        beat_a(x1, lbl);
    endtask

    task automatic clear_a();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic rd_a(input logic [1:0] idx, output logic signed [7:0] v);
        w_idx = idx;
        #1 v = w_rd;
    endtask

    task automatic train_a(output int cycles, output bit seen, output logic busy_n1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_n1 = busy;
        cycles = 0; seen = 1'b0;
        for (int k = 1; k <= 3000; k++) begin
            if (done) begin seen = 1'b1; cycles = k - 1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic signed [7:0] v;
        total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL rst_load_ready_in_reset: got %b want 1", load_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy_in_reset: got %b want 0", busy); end
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (n_loaded !== 3'd0) begin bad++; $display("FAIL rst_n_loaded: got %0d want 0", n_loaded); end
        total++; if ({done, converged} !== 2'b00) begin bad++; $display("FAIL rst_done_conv: got %b want 00", {done, converged}); end
        total++; if (epochs !== 8'd0) begin bad++; $display("FAIL rst_epochs: got %0d want 0", epochs); end
        for (int i = 0; i < 4; i++) begin
            rd_a(2'(i), v);
            total++; if (v !== 8'sd0) begin bad++; $display("FAIL rst_w_rd[%0d]: got %0d want 0", i, v); end
        end
        total++; if (b_load_ready !== 1'b1) begin bad++; $display("FAIL rst_b_load_ready: got %b want 1", b_load_ready); end
    endtask

    task automatic test_and();
        logic signed [7:0] exp_w [4] = '{8'sd2, 8'sd1, -8'sd2, 8'sd0};
        logic signed [7:0] v;
        int cyc; bit seen; logic b1;
        sample_a(0, 0, 0); sample_a(0, 1, 0); sample_a(1, 0, 0); sample_a(1, 1, 1);
        total++; if (n_loaded !== 3'd4) begin bad++; $display("FAIL and_n_loaded: got %0d want 4", n_loaded); end
        train_a(cyc, seen, b1);
        total++; if (b1 !== 1'b1) begin bad++; $display("FAIL and_busy_started: got %b want 1", b1); end
        total++; if (!seen) begin bad++; $display("FAIL and_done_timeout: got no done want done"); end
        total++; if (cyc != 78) begin bad++; $display("FAIL and_cycles: got %0d want 78", cyc); end
        total++; if (converged !== 1'b1) begin bad++; $display("FAIL and_converged: got %b want 1", converged); end
        total++; if (epochs !== 8'd6) begin bad++; $display("FAIL and_epochs: got %0d want 6", epochs); end
        @(negedge clk);
        total++; if ({done, busy} !== 2'b00) begin bad++; $display("FAIL and_done_pulse: got %b want 00", {done, busy}); end
        for (int i = 0; i < 4; i++) begin
            rd_a(2'(i), v);
            total++; if (v !== exp_w[i]) begin bad++; $display("FAIL and_w_rd[%0d]: got %0d want %0d", i, v, exp_w[i]); end
        end
    endtask

    task automatic test_xor();
        int cyc; bit seen; logic b1;
        clear_a();
        sample_a(0, 0, 0); sample_a(0, 1, 1); sample_a(1, 0, 1); sample_a(1, 1, 0);
        train_a(cyc, seen, b1);
        total++; if (!seen) begin bad++; $display("FAIL xor_done_timeout: got no done want done"); end
        total++; if (cyc != 195) begin bad++; $display("FAIL xor_cycles: got %0d want 195", cyc); end
        total++; if (converged !== 1'b0) begin bad++; $display("FAIL xor_converged: got %b want 0", converged); end
        total++; if (epochs !== 8'd15) begin bad++; $display("FAIL xor_epochs: got %0d want 15", epochs); end
    endtask

    task automatic test_full_store();
        logic signed [7:0] v;
        @(negedge clk);
        load_valid = 1'b1; load_x = 4'sd3; load_label = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL full_load_ready: got %b want 0", load_ready); end
        total++; if (n_loaded !== 3'd4) begin bad++; $display("FAIL full_n_loaded: got %0d want 4", n_loaded); end
        total++; if (epochs !== 8'd15) begin bad++; $display("FAIL full_epochs_hold: got %0d want 15", epochs); end
        load_valid = 1'b0;
        clear_a();
        total++; if (n_loaded !== 3'd0) begin bad++; $display("FAIL clear_n_loaded: got %0d want 0", n_loaded); end
        total++; if (epochs !== 8'd0) begin bad++; $display("FAIL clear_epochs: got %0d want 0", epochs); end
        rd_a(2'd0, v);
        total++; if (v !== 8'sd0) begin bad++; $display("FAIL clear_w0: got %0d want 0", v); end
        rd_a(2'd2, v);
        total++; if (v !== 8'sd0) begin bad++; $display("FAIL clear_bias: got %0d want 0", v); end
    endtask

    task automatic test_start_guards();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL guard_empty_start: got busy=%b want 0", busy); end
        beat_a(1, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL guard_partial_start: got busy=%b want 0", busy); end
        beat_a(1, 1);
        total++; if (n_loaded !== 3'd1) begin bad++; $display("FAIL guard_n_loaded: got %0d want 1", n_loaded); end
    endtask

    task automatic test_start_with_beat();
        start = 1'b1; load_valid = 1'b1; load_x = 4'sd0; load_label = 1'b0;
        @(negedge clk);
        start = 1'b0; load_valid = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL beat_start_busy: got %b want 0", busy); end
        total++; if (n_loaded !== 3'd1) begin bad++; $display("FAIL beat_start_partial: got %0d want 1", n_loaded); end
        beat_a(0, 0);
        total++; if (n_loaded !== 3'd2) begin bad++; $display("FAIL beat_start_complete: got %0d want 2", n_loaded); end
    endtask

    task automatic test_reset_mid();
        logic signed [7:0] v;
        int seen_done;
        clear_a();
        sample_a(0, 0, 0); sample_a(0, 1, 0); sample_a(1, 0, 0); sample_a(1, 1, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy_in_reset: got %b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        total++; if (n_loaded !== 3'd0) begin bad++; $display("FAIL mid_n_loaded: got %0d want 0", n_loaded); end
        total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL mid_load_ready: got %b want 1", load_ready); end
        for (int i = 0; i < 4; i++) begin
            rd_a(2'(i), v);
            total++; if (v !== 8'sd0) begin bad++; $display("FAIL mid_w_rd[%0d]: got %0d want 0", i, v); end
        end
        seen_done = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        total++; if (seen_done != 0) begin bad++; $display("FAIL mid_no_done: got %0d active cycles want 0", seen_done); end
    endtask

    task automatic test_narrow();
        int cyc; bit seen;
        @(negedge clk);
        b_load_valid = 1'b1; b_load_x = 4'sd0; b_load_label = 1'b1;
        @(negedge clk);
        b_load_x = -4'sd8; b_load_label = 1'b0;
        @(negedge clk);
        b_load_valid = 1'b0;
        total++; if (b_n_loaded !== 2'd2) begin bad++; $display("FAIL b_n_loaded: got %0d want 2", b_n_loaded); end
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        cyc = 0; seen = 1'b0;
        for (int k = 1; k <= 1000; k++) begin
            if (b_done) begin seen = 1'b1; cyc = k - 1; break; end
            @(negedge clk);
        end
        total++; if (!seen) begin bad++; $display("FAIL b_done_timeout: got no done want done"); end
        total++; if (cyc != B_CYCLES) begin bad++; $display("FAIL b_cycles: got %0d want %0d", cyc, B_CYCLES); end
        total++; if (b_converged !== 1'(B_CONV)) begin bad++; $display("FAIL b_converged: got %b want %0d", b_converged, B_CONV); end
        total++; if (b_epochs !== 8'(B_EPOCHS)) begin bad++; $display("FAIL b_epochs: got %0d want %0d", b_epochs, B_EPOCHS); end
        b_w_idx = 1'b0;
        #1;
        total++; if (b_w_rd !== 4'(B_W0)) begin bad++; $display("FAIL b_w0: got %0d want %0d", b_w_rd, B_W0); end
        b_w_idx = 1'b1;
        #1;
        total++; if (b_w_rd !== 4'(B_BIAS)) begin bad++; $display("FAIL b_bias: got %0d want %0d", b_w_rd, B_BIAS); end
    endtask

    initial begin
        rst_n = 1'b0;
        clear = 1'b0; load_valid = 1'b0; load_label = 1'b0; start = 1'b0; load_x = '0; w_idx = '0;
        b_clear = 1'b0; b_load_valid = 1'b0; b_load_label = 1'b0; b_start = 1'b0; b_load_x = '0; b_w_idx = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_and();
        test_xor();
        test_full_store();
        test_start_guards();
        test_start_with_beat();
        test_reset_mid();
        test_narrow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
